lcd_bus_controller: RTL and testbench

LCD_BUS_CONTROLLER -- requirements
Module: lcd_bus_controller

---
 rtl/lcd_pkg.sv | 30 +++
 rtl/lcd_cmd_fifo.sv | 54 +++++
 rtl/lcd_bus_controller.sv | 191 +++++++++++++++++++
 tb/tb_lcd_bus_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD bus controller: FSM states,
// command FIFO entry layout and bus-width selection.
package lcd_pkg;

  localparam int BUS_8BIT = 0;
  localparam int BUS_4BIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_POLL,
    ST_WAIT
  } lcd_state_t;

  typedef struct packed {
    logic       rs;
    logic       read;
    logic [7:0] data;
  } lcd_entry_t;

  // Byte placed on lcdDataOut for one transfer; 4-bit mode uses [7:4] only.
  function automatic logic [7:0] bus_byte(input logic [7:0] d, input logic nib,
                                          input logic low);
    if (!nib) return d;
    return low ? {d[3:0], 4'h0} : {d[7:4], 4'h0};
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Command FIFO for the LCD controller: power-of-two depth, first-word
// fall-through head, pushes ignored when full and pops ignored when empty.
module lcd_cmd_fifo
  import lcd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  lcd_entry_t i_din,
  input  logic       i_pop,
  output lcd_entry_t o_dout,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  lcd_entry_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == (AW + 1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_dout  = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lcd_bus_controller.sv
// HD44780-style LCD bus controller: queues commands and sequences
// SETUP/PULSE/HOLD transfers, with busy-flag polling or a fixed post-write wait.
module lcd_bus_controller
  import lcd_pkg::*;
#(
  parameter int SETUP       = 2,
  parameter int PULSE       = 4,
  parameter int HOLD        = 2,
  parameter int NIBBLE      = 0,
  parameter int DEPTH       = 4,
  parameter int BUSY_POLL   = 1,
  parameter int WAIT_CYCLES = 2000,
  parameter int POLL_LIMIT  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inValid,
  output logic       inReady,
  input  logic       inRS,
  input  logic       inRead,
  input  logic [7:0] inData,
  output logic       rdValid,
  output logic [7:0] rdData,
  output logic       busy,
  output logic       timeout,
  output logic       lcdRS,
  output logic       lcdRW,
  output logic       lcdE,
  output logic [7:0] lcdDataOut,
  input  logic [7:0] lcdDataIn
);

  localparam logic NIB_MODE = (NIBBLE == BUS_4BIT);

  lcd_state_t r_state;
  logic [31:0] r_cnt;
  logic [31:0] r_polls;
  logic        r_half;
  logic        r_status;
  logic        r_cmdRead;
  logic [7:0]  r_cmdData;
  logic [7:0]  r_rdbyte;
  logic        r_rdValid;
  logic [7:0]  r_rdData;
  logic        r_timeout;
  logic        r_lcdRS;
  logic        r_lcdRW;
  logic        r_lcdE;
  logic [7:0]  r_lcdDataOut;

  lcd_entry_t w_din;
  lcd_entry_t w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_pop;

  assign w_din = '{rs: inRS, read: inRead, data: inData};
  assign w_pop = (r_state == ST_IDLE) && !w_empty;

  lcd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (inValid),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign inReady    = !w_full;
  assign busy       = !w_empty || (r_state != ST_IDLE);
  assign rdValid    = r_rdValid;
  assign rdData     = r_rdData;
  assign timeout    = r_timeout;
  assign lcdRS      = r_lcdRS;
  assign lcdRW      = r_lcdRW;
  assign lcdE       = r_lcdE;
  assign lcdDataOut = r_lcdDataOut;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_polls      <= '0;
      r_half       <= 1'b0;
      r_status     <= 1'b0;
      r_cmdRead    <= 1'b0;
      r_cmdData    <= '0;
      r_rdbyte     <= '0;
      r_rdValid    <= 1'b0;
      r_rdData     <= '0;
      r_timeout    <= 1'b0;
      r_lcdRS      <= 1'b0;
      r_lcdRW      <= 1'b0;
      r_lcdE       <= 1'b0;
      r_lcdDataOut <= '0;
    end else begin
      r_rdValid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_cmdRead    <= w_head.read;
            r_cmdData    <= w_head.data;
            r_status     <= 1'b0;
            r_half       <= 1'b0;
            r_cnt        <= '0;
            r_lcdRS      <= w_head.rs;
            r_lcdRW      <= w_head.read;
            r_lcdDataOut <= w_head.read ? '0 : bus_byte(w_head.data, NIB_MODE, 1'b0);
            r_state      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_cnt == 32'(SETUP - 1)) begin
            r_cnt   <= '0;
            r_lcdE  <= 1'b1;
            r_state <= ST_PULSE;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        ST_PULSE: begin
          if (r_cnt == 32'(PULSE - 1)) begin
            r_cnt   <= '0;
            r_lcdE  <= 1'b0;
            r_state <= ST_HOLD;
            if (r_lcdRW) begin
              if (!NIB_MODE)   r_rdbyte      <= lcdDataIn;
              else if (r_half) r_rdbyte[3:0] <= lcdDataIn[7:4];
              else             r_rdbyte[7:4] <= lcdDataIn[7:4];
            end
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        ST_HOLD: begin
          if (r_cnt == 32'(HOLD - 1)) begin
            r_cnt <= '0;
            if (NIB_MODE && !r_half) begin
              r_half       <= 1'b1;
              r_lcdDataOut <= r_lcdRW ? '0 : bus_byte(r_cmdData, 1'b1, 1'b1);
              r_state      <= ST_SETUP;
            end else if (r_status) begin
              // Busy-flag result of a status read decides retry, timeout or done.
              if (!r_rdbyte[7]) begin
                r_state <= ST_IDLE;
              end else if (r_polls == 32'(POLL_LIMIT - 1)) begin
                r_timeout <= 1'b1;
                r_state   <= ST_IDLE;
              end else begin
                r_polls <= r_polls + 32'd1;
                r_state <= ST_POLL;
              end
            end else if (r_cmdRead) begin
              r_rdValid <= 1'b1;
              r_rdData  <= r_rdbyte;
              r_state   <= ST_IDLE;
            end else if (BUSY_POLL != 0) begin
              r_polls <= '0;
              r_state <= ST_POLL;
            end else begin
              r_state <= ST_WAIT;
            end
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        ST_POLL: begin
          r_status     <= 1'b1;
          r_half       <= 1'b0;
          r_cnt        <= '0;
          r_lcdRS      <= 1'b0;
          r_lcdRW      <= 1'b1;
          r_lcdDataOut <= '0;
          r_state      <= ST_SETUP;
        end
        ST_WAIT: begin
          if (r_cnt == 32'(WAIT_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_controller.sv
// Directed bench for lcd_bus_controller: three instances (polling with a short
// poll limit, 4-bit bus, fixed wait) sharing one clock and reset.
module tb_lcd_bus_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0]      inValid = '0, inRS = '0, inRead = '0;
  logic [2:0][7:0] inData = '0, lcdDataIn = '0;
  logic [2:0]      inReady, rdValid, busy, timeout, lcdRS, lcdRW, lcdE;
  logic [2:0][7:0] rdData, lcdDataOut;

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;

  // Pulse monitor: {RS,RW,data} at each E rise, width, rise/fall cycle stamps.
  logic [9:0] plog  [3][64];
  int         wlog  [3][64];
  int         erise [3][64];
  int         efall [3][64];
  int         pcnt  [3] = '{0, 0, 0};
  int         rcnt  [3] = '{0, 0, 0};
  int         wcur  [3] = '{0, 0, 0};
  logic [7:0] rdlast[3] = '{8'h00, 8'h00, 8'h00};
  logic [2:0] eprev = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (lcdE[i] && !eprev[i]) begin
        if (pcnt[i] < 64) begin
          plog[i][pcnt[i]]  = {lcdRS[i], lcdRW[i], lcdDataOut[i]};
          erise[i][pcnt[i]] = cyc;
        end
        wcur[i] = 0;
      end
      if (lcdE[i]) wcur[i]++;
      if (!lcdE[i] && eprev[i]) begin
        if (pcnt[i] < 64) begin
          wlog[i][pcnt[i]]  = wcur[i];
          efall[i][pcnt[i]] = cyc;
        end
        pcnt[i]++;
      end
      if (rdValid[i]) begin
        rcnt[i]++;
        rdlast[i] = rdData[i];
      end
      eprev[i] = lcdE[i];
    end
  end

  lcd_bus_controller #(.POLL_LIMIT(3)) u_a (
    .clk(clk), .rst(rst), .inValid(inValid[0]), .inReady(inReady[0]), .inRS(inRS[0]),
    .inRead(inRead[0]), .inData(inData[0]), .rdValid(rdValid[0]), .rdData(rdData[0]),
    .busy(busy[0]), .timeout(timeout[0]), .lcdRS(lcdRS[0]), .lcdRW(lcdRW[0]),
    .lcdE(lcdE[0]), .lcdDataOut(lcdDataOut[0]), .lcdDataIn(lcdDataIn[0]));

  lcd_bus_controller #(.NIBBLE(1)) u_b (
    .clk(clk), .rst(rst), .inValid(inValid[1]), .inReady(inReady[1]), .inRS(inRS[1]),
    .inRead(inRead[1]), .inData(inData[1]), .rdValid(rdValid[1]), .rdData(rdData[1]),
    .busy(busy[1]), .timeout(timeout[1]), .lcdRS(lcdRS[1]), .lcdRW(lcdRW[1]),
    .lcdE(lcdE[1]), .lcdDataOut(lcdDataOut[1]), .lcdDataIn(lcdDataIn[1]));

  lcd_bus_controller #(.BUSY_POLL(0), .WAIT_CYCLES(10)) u_c (
    .clk(clk), .rst(rst), .inValid(inValid[2]), .inReady(inReady[2]), .inRS(inRS[2]),
    .inRead(inRead[2]), .inData(inData[2]), .rdValid(rdValid[2]), .rdData(rdData[2]),
    .busy(busy[2]), .timeout(timeout[2]), .lcdRS(lcdRS[2]), .lcdRW(lcdRW[2]),
    .lcdE(lcdE[2]), .lcdDataOut(lcdDataOut[2]), .lcdDataIn(lcdDataIn[2]));

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input int i, input logic rs, input logic rd, input logic [7:0] d,
                      output int waited);
    inValid[i] = 1'b1; inRS[i] = rs; inRead[i] = rd; inData[i] = d;
    waited = 0;
    while (!inReady[i] && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    inValid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, output logic ok);
    int n = 0;
    while (busy[i] && n < 600) begin
      @(negedge clk);
      n++;
    end
    ok = !busy[i];
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if ({inReady[i], busy[i], rdValid[i], timeout[i], lcdE[i], lcdRS[i], lcdRW[i]} !== 7'b1000000) begin
        nmis++;
        $display("FAIL reset_ctrl[%0d]: got %b want 1000000", i,
                 {inReady[i], busy[i], rdValid[i], timeout[i], lcdE[i], lcdRS[i], lcdRW[i]});
      end
      nvec++;
      if ({rdData[i], lcdDataOut[i]} !== 16'h0000) begin
        nmis++;
        $display("FAIL reset_data[%0d]: got %h want 0000", i, {rdData[i], lcdDataOut[i]});
      end
    end
  endtask

  task automatic test_write_poll();
    int b, rb, w;
    logic ok;
    lcdDataIn[0] = 8'h00; b = pcnt[0]; rb = rcnt[0];
    push(0, 1'b1, 1'b0, 8'h41, w);
    wait_idle(0, ok);
    nvec++; if (ok !== 1'b1) begin nmis++; $display("FAIL wp_idle: busy still %b want 0", busy[0]); end
    nvec++; if (pcnt[0] - b != 2) begin nmis++; $display("FAIL wp_pulses: got %0d want 2", pcnt[0] - b); end
    nvec++; if (plog[0][b] !== 10'h241) begin nmis++; $display("FAIL wp_bus: got %h want 241", plog[0][b]); end
    nvec++; if (wlog[0][b] != 4) begin nmis++; $display("FAIL wp_width: got %0d want 4", wlog[0][b]); end
    nvec++; if (plog[0][b+1] !== 10'h100) begin nmis++; $display("FAIL wp_status: got %h want 100", plog[0][b+1]); end
    nvec++; if (rcnt[0] != rb) begin nmis++; $display("FAIL wp_rdvalid: got %0d want 0", rcnt[0] - rb); end
  endtask

  task automatic test_timeout();
    int b, w;
    logic ok;
    lcdDataIn[0] = 8'h80; b = pcnt[0];
    push(0, 1'b0, 1'b0, 8'h01, w);
    wait_idle(0, ok);
    nvec++; if (pcnt[0] - b != 4) begin nmis++; $display("FAIL to_polls: got %0d want 4 pulses", pcnt[0] - b); end
    nvec++; if (timeout[0] !== 1'b1) begin nmis++; $display("FAIL to_set: got %b want 1", timeout[0]); end
    lcdDataIn[0] = 8'h00;
    push(0, 1'b0, 1'b0, 8'h38, w);
    wait_idle(0, ok);
    nvec++; if (ok !== 1'b1) begin nmis++; $display("FAIL to_next_idle: busy %b want 0", busy[0]); end
    nvec++; if (plog[0][b+4] !== 10'h038) begin nmis++; $display("FAIL to_next_bus: got %h want 038", plog[0][b+4]); end
    nvec++; if (pcnt[0] - b != 6) begin nmis++; $display("FAIL to_next_pulses: got %0d want 6", pcnt[0] - b); end
    nvec++; if (timeout[0] !== 1'b1) begin nmis++; $display("FAIL to_sticky: got %b want 1", timeout[0]); end
  endtask

  task automatic test_fifo_full();
    int b, w, w5;
    logic ok;
    lcdDataIn[0] = 8'h00; b = pcnt[0];
    for (int k = 0; k < 5; k++) push(0, 1'b1, 1'b0, 8'(8'h10 + k), w);
    nvec++; if (inReady[0] !== 1'b0) begin nmis++; $display("FAIL ff_full: inReady %b want 0", inReady[0]); end
    push(0, 1'b1, 1'b0, 8'h15, w5);
    nvec++; if (w5 == 0) begin nmis++; $display("FAIL ff_stall: waited %0d want >0", w5); end
    nvec++; if (pcnt[0] - b != 2) begin nmis++; $display("FAIL ff_accept_after_pop: pulses %0d want 2", pcnt[0] - b); end
    wait_idle(0, ok);
    nvec++; if (pcnt[0] - b != 12) begin nmis++; $display("FAIL ff_pulses: got %0d want 12", pcnt[0] - b); end
    for (int k = 0; k < 6; k++) begin
      nvec++;
      if (plog[0][b+2*k] !== {2'b10, 8'(8'h10 + k)}) begin
        nmis++;
        $display("FAIL ff_order[%0d]: got %h want %h", k, plog[0][b+2*k], {2'b10, 8'(8'h10 + k)});
      end
    end
  endtask

  task automatic test_nibble();
    int b, rb, w, n;
    logic ok;
    logic [9:0] expw [4] = '{10'h0C0, 10'h070, 10'h100, 10'h100};
    lcdDataIn[1] = 8'h5C; b = pcnt[1]; rb = rcnt[1];
    push(1, 1'b1, 1'b1, 8'hFF, w);
    n = 0;
    while (pcnt[1] - b < 1 && n < 100) begin @(negedge clk); n++; end
    lcdDataIn[1] = 8'hA3;
    wait_idle(1, ok);
    nvec++; if (pcnt[1] - b != 2) begin nmis++; $display("FAIL nb_rd_pulses: got %0d want 2", pcnt[1] - b); end
    nvec++; if (rcnt[1] - rb != 1) begin nmis++; $display("FAIL nb_rdvalid: got %0d want 1", rcnt[1] - rb); end
    nvec++; if (rdlast[1] !== 8'h5A) begin nmis++; $display("FAIL nb_rddata: got %h want 5a", rdlast[1]); end
    nvec++; if (rdData[1] !== 8'h5A) begin nmis++; $display("FAIL nb_rdhold: got %h want 5a", rdData[1]); end
    nvec++; if ({plog[1][b], plog[1][b+1]} !== {10'h300, 10'h300}) begin
      nmis++; $display("FAIL nb_rd_bus: got %h %h want 300 300", plog[1][b], plog[1][b+1]);
    end
    lcdDataIn[1] = 8'h00; b = pcnt[1];
    push(1, 1'b0, 1'b0, 8'hC7, w);
    wait_idle(1, ok);
    nvec++; if (pcnt[1] - b != 4) begin nmis++; $display("FAIL nb_wr_pulses: got %0d want 4", pcnt[1] - b); end
    for (int k = 0; k < 4; k++) begin
      nvec++;
      if (plog[1][b+k] !== expw[k]) begin
        nmis++; $display("FAIL nb_wr_bus[%0d]: got %h want %h", k, plog[1][b+k], expw[k]);
      end
    end
  endtask

  task automatic test_fixed_wait();
    int b, w;
    logic ok;
    b = pcnt[2];
    push(2, 1'b1, 1'b0, 8'h01, w);
    push(2, 1'b1, 1'b0, 8'h02, w);
    wait_idle(2, ok);
    nvec++; if (ok !== 1'b1) begin nmis++; $display("FAIL fw_idle: busy %b want 0", busy[2]); end
    nvec++; if (pcnt[2] - b != 2) begin nmis++; $display("FAIL fw_pulses: got %0d want 2", pcnt[2] - b); end
    nvec++; if ({plog[2][b], plog[2][b+1]} !== {10'h201, 10'h202}) begin
      nmis++; $display("FAIL fw_bus: got %h %h want 201 202", plog[2][b], plog[2][b+1]);
    end
    nvec++; if (erise[2][b+1] - efall[2][b] != 15) begin
      nmis++; $display("FAIL fw_gap: E fall to next rise %0d want 15", erise[2][b+1] - efall[2][b]);
    end
  endtask

  task automatic test_reset_mid();
    int b, rb, w, n;
    lcdDataIn[0] = 8'h00; rb = rcnt[0];
    push(0, 1'b1, 1'b1, 8'h00, w);
    push(0, 1'b0, 1'b0, 8'h77, w);
    push(0, 1'b0, 1'b0, 8'h78, w);
    n = 0;
    while (!lcdE[0] && n < 50) begin @(negedge clk); n++; end
    nvec++; if (lcdE[0] !== 1'b1) begin nmis++; $display("FAIL rm_reach_pulse: lcdE %b want 1", lcdE[0]); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nvec++; if (lcdE[0] !== 1'b0) begin nmis++; $display("FAIL rm_e_low: lcdE %b want 0", lcdE[0]); end
    nvec++; if ({busy[0], inReady[0], timeout[0]} !== 3'b010) begin
      nmis++; $display("FAIL rm_state: busy/inReady/timeout %b want 010", {busy[0], inReady[0], timeout[0]});
    end
    @(negedge clk);
    b = pcnt[0];
    repeat (30) @(negedge clk);
    nvec++; if (pcnt[0] != b) begin nmis++; $display("FAIL rm_fifo_empty: %0d pulses after reset want 0", pcnt[0] - b); end
    nvec++; if (rcnt[0] != rb) begin nmis++; $display("FAIL rm_no_rdvalid: got %0d want 0", rcnt[0] - rb); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_write_poll();
    test_timeout();
    test_fifo_full();
    test_nibble();
    test_fixed_wait();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
